// File: rtl/fetch_packet_queue.sv
// Dual-issue fetch packet queue between fetch and decode: single-instruction circular buffer
// presenting the two oldest entries as the A/B issue pair. Optional macro: FETCHQ_BYPASS_EN.
module fetch_packet_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_inst0,
    input  logic [XLEN-1:0]          enq_inst1,
    input  logic                     enq_two,
    output logic                     a_valid,
    output logic [XLEN-1:0]          a_pc,
    output logic [XLEN-1:0]          a_inst,
    output logic                     b_valid,
    output logic [XLEN-1:0]          b_pc,
    output logic [XLEN-1:0]          b_inst,
    input  logic [1:0]               deq_count,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     deq_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pc_mem_r   [DEPTH];
    logic [XLEN-1:0] inst_mem_r [DEPTH];
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic            deq_err_r;
    logic            enq_ready_r;

    logic            enq_fire_s;
    logic [CW-1:0]   nenq_s;
    logic [CW-1:0]   deq_req_s;
    logic [CW-1:0]   avail_s;
    logic [CW-1:0]   eff_s;
    logic            over_s;
    logic [CW-1:0]   count_next_s;
    logic [PW-1:0]   head1_s;
    logic [PW-1:0]   tail1_s;
    logic [XLEN-1:0] pc1_s;
`ifdef FETCHQ_BYPASS_EN
    logic            bypass_s;
`endif

    // Enqueue/dequeue bookkeeping for this cycle
    always_comb begin
        enq_fire_s = enq_valid & enq_ready_r;
        nenq_s     = enq_fire_s ? (enq_two ? CW'(2) : CW'(1)) : CW'(0);
        deq_req_s  = CW'(deq_count);
`ifdef FETCHQ_BYPASS_EN
        // An empty queue hands the incoming packet straight to decode
        bypass_s   = reset & ~flush & enq_fire_s & (count_r == CW'(0));
        avail_s    = bypass_s ? nenq_s : count_r;
`else
        avail_s    = count_r;
`endif
        over_s       = deq_req_s > avail_s;
        eff_s        = over_s ? avail_s : deq_req_s;
        count_next_s = count_r + nenq_s - eff_s;
        head1_s      = head_r + PW'(1);
        tail1_s      = tail_r + PW'(1);
        pc1_s        = enq_pc + XLEN'(4);
    end

    // Pointer, occupancy, ready and sticky error state
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_r      <= PW'(0);
            tail_r      <= PW'(0);
            count_r     <= CW'(0);
            deq_err_r   <= 1'b0;
            enq_ready_r <= 1'b1;
        end else if (flush) begin
            head_r      <= PW'(0);
            tail_r      <= PW'(0);
            count_r     <= CW'(0);
            enq_ready_r <= 1'b1;
        end else begin
            head_r      <= head_r + PW'(eff_s);
            tail_r      <= tail_r + PW'(nenq_s);
            count_r     <= count_next_s;
            deq_err_r   <= deq_err_r | over_s;
            enq_ready_r <= count_next_s <= CW'(DEPTH - 2);
        end
    end

    // Entry storage writes; consumed bypass entries land behind head and are never read
    always_ff @(posedge clock) begin
        if (reset && !flush && enq_fire_s) begin
            pc_mem_r[tail_r]   <= enq_pc;
            inst_mem_r[tail_r] <= enq_inst0;
            if (enq_two) begin
                pc_mem_r[tail1_s]   <= pc1_s;
                inst_mem_r[tail1_s] <= enq_inst1;
            end
        end
    end

    // A/B issue pair; empty slots present pc 0 and a NOP
    always_comb begin
        a_valid = count_r >= CW'(1);
        b_valid = count_r >= CW'(2);
        a_pc    = a_valid ? pc_mem_r[head_r]    : XLEN'(0);
        a_inst  = a_valid ? inst_mem_r[head_r]  : NOP_INST;
        b_pc    = b_valid ? pc_mem_r[head1_s]   : XLEN'(0);
        b_inst  = b_valid ? inst_mem_r[head1_s] : NOP_INST;
`ifdef FETCHQ_BYPASS_EN
        if (bypass_s) begin
            a_valid = 1'b1;
            a_pc    = enq_pc;
            a_inst  = enq_inst0;
            b_valid = enq_two;
            b_pc    = enq_two ? pc1_s     : XLEN'(0);
            b_inst  = enq_two ? enq_inst1 : NOP_INST;
        end else begin
            a_valid = a_valid;
        end
`endif
    end

    assign enq_ready = enq_ready_r;
    assign count     = count_r;
    assign deq_err   = deq_err_r;

endmodule
